// File: rtl/fm_demod_pkg.sv
// Shared constants and sample type for the FM demodulator chain (FIR, decimator, demodulator).
package fm_demod_pkg;

  localparam int unsigned SampleWidth      = 16;
  localparam int unsigned DefaultDecim     = 4;
  localparam int unsigned DefaultFifoDepth = 4;

  typedef logic signed [SampleWidth-1:0] sample_t;

endpackage

// File: rtl/fir_decim_if.sv
// Sample-in / decimated-sample-out bundle of the FIR decimator.
interface fir_decim_if
  import fm_demod_pkg::*;
#(
  parameter int unsigned WIDTH      = SampleWidth,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
);

  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic                    valid_i;
  logic signed [WIDTH-1:0] data_i;
  logic                    ready_i;
  logic                    clr_ovf_i;
  logic                    valid_o;
  logic signed [WIDTH-1:0] data_o;
  logic [LevelW-1:0]       level_o;
  logic                    overflow_o;

  modport master (
    output valid_i, data_i, ready_i, clr_ovf_i,
    input  valid_o, data_o, level_o, overflow_o
  );

  modport slave (
    input  valid_i, data_i, ready_i, clr_ovf_i,
    output valid_o, data_o, level_o, overflow_o
  );

endinterface

// File: rtl/fm_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted only
// when a pop frees the slot on the same edge. rdata reads 0 while empty.
module fm_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/fir_decim.sv
// Decimate-by-DECIM stage with output FIFO and sticky overflow flag.
// Define FIR_DECIM_AVG_EN to output the rounded mean of each group instead of its last sample.
module fir_decim
  import fm_demod_pkg::*;
#(
  parameter int unsigned WIDTH      = SampleWidth,
  parameter int unsigned DECIM      = DefaultDecim,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
  input logic       clk,
  input logic       rst,
  fir_decim_if.slave bus
);

  localparam int unsigned PhW    = $clog2(DECIM);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic [PhW-1:0]    phase_q, phase_d;
  logic              last_phase, push, pop, full, empty;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  sample, rdata;
  logic [LevelW-1:0] level;

  assign last_phase = (phase_q == PhW'(DECIM - 1));
  assign push       = bus.valid_i && last_phase;
  assign pop        = bus.ready_i && !empty;

  always_comb begin
    phase_d = phase_q;
    if (bus.valid_i) phase_d = last_phase ? '0 : phase_q + 1'b1;
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned AccW = WIDTH + 4;
  localparam logic signed [AccW-1:0] Round = AccW'(DECIM / 2);

  logic signed [AccW-1:0] acc_q, acc_sum, rounded;

  // Phase 0 restarts the sum so a group never inherits a stale partial.
  always_comb begin
    acc_sum = (phase_q == '0) ? '0 : acc_q;
    acc_sum = acc_sum + {{4{bus.data_i[WIDTH-1]}}, bus.data_i};
    rounded = acc_sum + Round;
    sample  = WIDTH'(rounded >>> PhW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (bus.valid_i) begin
      acc_q <= acc_sum;
    end
  end
`else
  assign sample = bus.data_i;
`endif

  // A coinciding drop wins over clear so no overflow event is lost.
  assign ovf_d = (push && full && !pop) || (ovf_q && !bus.clr_ovf_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
    end
  end

  fm_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (sample),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.valid_o    = !empty;
  assign bus.data_o     = rdata;
  assign bus.level_o    = level;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_fir_decim.sv
// Self-checking bench for fir_decim: directed scenarios plus random traffic against a queue model.
module tb_fir_decim;
  import fm_demod_pkg::*;

  localparam int unsigned WIDTH      = SampleWidth;
  localparam int unsigned DECIM      = DefaultDecim;
  localparam int unsigned FIFO_DEPTH = DefaultFifoDepth;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_decim_if #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  fir_decim #(
    .WIDTH      (WIDTH),
    .DECIM      (DECIM),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of decimated samples, strobe count and group sum.
  int q[$];
  int n_strobe;
  int grp_sum;
  bit m_ovf;

  function automatic int floor_div(int a, int b);
    int r;
    r = a / b;
    if ((a % b != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  function automatic int decimate(int sum, int last);
`ifdef FIR_DECIM_AVG_EN
    return floor_div(sum + int'(DECIM / 2), int'(DECIM));
`else
    return last;
`endif
  endfunction

  function automatic int rnd_sample();
    logic signed [WIDTH-1:0] s;
    s = WIDTH'($urandom);
    return int'(s);
  endfunction

  task automatic model_reset();
    q.delete();
    n_strobe = 0;
    grp_sum  = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(bit v, int d, bit r, bit c);
    bit pop, push, drop;
    int smp;
    pop  = r && (q.size() != 0);
    push = 1'b0;
    smp  = 0;
    if (v) begin
      grp_sum  += d;
      n_strobe += 1;
      if (n_strobe % int'(DECIM) == 0) begin
        push    = 1'b1;
        smp     = decimate(grp_sum, d);
        grp_sum = 0;
      end
    end
    if (pop) void'(q.pop_front());
    drop = push && (q.size() >= int'(FIFO_DEPTH));
    if (push && !drop) q.push_back(smp);
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".valid"}, bus.valid_o, (q.size() != 0));
    chk({tag, ".data"}, bus.data_o, (q.size() != 0) ? q[0] : 0);
    chk({tag, ".level"}, bus.level_o, q.size());
    chk({tag, ".ovf"}, bus.overflow_o, m_ovf);
  endtask

  task automatic cycle(bit v, int d, bit r, bit c, string tag);
    bus.valid_i   = v;
    bus.data_i    = d[WIDTH-1:0];
    bus.ready_i   = r;
    bus.clr_ovf_i = c;
    @(posedge clk);
    model_edge(v, d, r, c);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int saved[$];
    int exp_v;
    bus.valid_i   = 1'b0;
    bus.data_i    = '0;
    bus.ready_i   = 1'b0;
    bus.clr_ovf_i = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Strobes every second cycle, data 1..12, downstream always ready
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, i, 1'b1, 1'b0, "seq_strobe");
      if (i % 4 == 0) begin
`ifdef FIR_DECIM_AVG_EN
        exp_v = i - 1;
`else
        exp_v = i;
`endif
        chk("seq_valid_latency", bus.valid_o, 1);
        chk("seq_value", bus.data_o, exp_v);
      end
      cycle(1'b0, 0, 1'b1, 1'b0, "seq_gap");
    end

    // Rounding groups: 100..103 and -1,-2,-2,-2
    for (int i = 0; i < 4; i++) cycle(1'b1, 100 + i, 1'b1, 1'b0, "grp_a");
`ifdef FIR_DECIM_AVG_EN
    chk("grp_a_value", bus.data_o, 102);
`else
    chk("grp_a_value", bus.data_o, 103);
`endif
    cycle(1'b1, -1, 1'b1, 1'b0, "grp_b");
    for (int i = 0; i < 3; i++) cycle(1'b1, -2, 1'b1, 1'b0, "grp_b");
    chk("grp_b_value", bus.data_o, -2);
    cycle(1'b0, 0, 1'b1, 1'b0, "grp_b_pop");

    // Back-pressure: 20 strobes into a stalled FIFO
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, rnd_sample(), 1'b0, 1'b0, "stall");
      if (i == 16) begin
        chk("stall_level_full", bus.level_o, FIFO_DEPTH);
        chk("stall_no_ovf_yet", bus.overflow_o, 0);
      end
    end
    chk("stall_ovf_on_5th_push", bus.overflow_o, 1);
    saved = q;
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", bus.data_o, saved[k]);
      cycle(1'b0, 0, 1'b1, 1'b0, "drain");
    end
    chk("drain_empty", bus.level_o, 0);
    cycle(1'b0, 0, 1'b0, 1'b1, "clr_after_drain");

    // Full FIFO, push and pop on the same edge
    for (int i = 0; i < 16; i++) cycle(1'b1, rnd_sample(), 1'b0, 1'b0, "fill");
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_sample(), 1'b0, 1'b0, "fill_part");
    saved = q;
    cycle(1'b1, rnd_sample(), 1'b1, 1'b0, "push_pop_full");
    chk("push_pop_level", bus.level_o, FIFO_DEPTH);
    chk("push_pop_no_ovf", bus.overflow_o, 0);
    chk("push_pop_head", bus.data_o, saved[1]);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b0, "push_pop_drain");

    // Reset in the middle of a decimation group
    cycle(1'b1, rnd_sample(), 1'b1, 1'b0, "mid_a");
    cycle(1'b1, rnd_sample(), 1'b1, 1'b0, "mid_b");
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid", bus.valid_o, 0);
    chk("midrst_data", bus.data_o, 0);
    chk("midrst_level", bus.level_o, 0);
    chk("midrst_ovf", bus.overflow_o, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, rnd_sample(), 1'b1, 1'b0, "after_rst");
      if (i == 3) chk("after_rst_3rd_none", bus.valid_o, 0);
      if (i == 4) chk("after_rst_4th_out", bus.valid_o, 1);
    end
    cycle(1'b0, 0, 1'b1, 1'b0, "after_rst_pop");

    // Clear coinciding with a new overflow, then clear alone
    for (int i = 0; i < 20; i++) cycle(1'b1, rnd_sample(), 1'b0, 1'b0, "ovf_fill");
    chk("ovf_set", bus.overflow_o, 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_sample(), 1'b0, 1'b0, "ovf_part");
    cycle(1'b1, rnd_sample(), 1'b0, 1'b1, "ovf_clr_clash");
    chk("ovf_clr_clash_holds", bus.overflow_o, 1);
    cycle(1'b0, 0, 1'b0, 1'b1, "ovf_clr_alone");
    chk("ovf_cleared", bus.overflow_o, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), rnd_sample(), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
